// File: rtl/rv32i_pkg.sv
// Shared widths and the writeback request record used by the arbiter and its queues.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REQ    = 2;

    // "reg" is a keyword, so the destination field is named rd.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rv32i_wb_fifo.sv
// Per-requester writeback queue; exposes every slot's valid/rd for the hazard lookup.
module rv32i_wb_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  wb_req_t                           push_entry,
    input  logic                              pop,
    output logic                              full,
    output logic                              empty,
    output wb_req_t                           head,
    output logic [DEPTH-1:0]                  entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_rd
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // The extra MSB separates a full queue from an empty one when indices match.
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[PW-1:0]] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offset;
            assign offset          = PW'(gi) - rd_ptr_reg[PW-1:0];
            assign entry_valid[gi] = ({1'b0, offset} < count);
            assign entry_rd[gi]    = mem[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Two-requester register-file writeback arbiter with alternating priority and
// a combinational pending lookup for the decode stage.
module rv32i_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      req_data,
    output logic                              wb_enable,
    output logic [REG_ADDR_W-1:0]             wb_reg,
    output logic [XLEN-1:0]                   wb_data,
    input  logic [REG_ADDR_W-1:0]             rs1_reg,
    input  logic [REG_ADDR_W-1:0]             rs2_reg,
    output logic                              rs1_pending,
    output logic                              rs2_pending
);

    logic [NUM_REQ-1:0]                                  fifo_full;
    logic [NUM_REQ-1:0]                                  fifo_empty;
    wb_req_t                                             fifo_head [NUM_REQ];
    logic [NUM_REQ-1:0][FIFO_DEPTH-1:0]                  entry_valid;
    logic [NUM_REQ-1:0][FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  entry_rd;
    logic [NUM_REQ-1:0]                                  grant;
    logic                                                last_grant_reg;
    wb_req_t                                             granted;
    logic                                                rs1_hit;
    logic                                                rs2_hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            wb_req_t push_entry;
            assign push_entry    = '{rd: req_reg[gi], data: req_data[gi]};
            // Held low in reset so nothing is offered while the queues are cleared.
            assign req_ready[gi] = !fifo_full[gi] && reset;

            rv32i_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk         (clk),
                .reset       (reset),
                .push        (req_valid[gi]),
                .push_entry  (push_entry),
                .pop         (grant[gi]),
                .full        (fifo_full[gi]),
                .empty       (fifo_empty[gi]),
                .head        (fifo_head[gi]),
                .entry_valid (entry_valid[gi]),
                .entry_rd    (entry_rd[gi])
            );
        end
    endgenerate

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        grant = '0;
        if (!fifo_empty[0] && !fifo_empty[1]) grant = last_grant_reg ? 2'b01 : 2'b10;
        else if (!fifo_empty[0])              grant = 2'b01;
        else if (!fifo_empty[1])              grant = 2'b10;
    end

    assign granted = grant[1] ? fifo_head[1] : fifo_head[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= 1'b1;
            wb_enable      <= 1'b0;
            wb_reg         <= '0;
            wb_data        <= '0;
        end else if (|grant) begin
            last_grant_reg <= grant[1];
            // Writes to x0 still burn the grant but never reach the register file.
            if (granted.rd != '0) begin
                wb_enable <= 1'b1;
                wb_reg    <= granted.rd;
                wb_data   <= granted.data;
            end else begin
                wb_enable <= 1'b0;
                wb_reg    <= '0;
                wb_data   <= '0;
            end
        end else begin
            wb_enable <= 1'b0;
        end
    end

    always_comb begin
        rs1_hit = wb_enable && (wb_reg == rs1_reg);
        rs2_hit = wb_enable && (wb_reg == rs2_reg);
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (entry_valid[r][e] && (entry_rd[r][e] == rs1_reg)) rs1_hit = 1'b1;
                if (entry_valid[r][e] && (entry_rd[r][e] == rs2_reg)) rs2_hit = 1'b1;
            end
        end
    end

    assign rs1_pending = rs1_hit && (rs1_reg != '0);
    assign rs2_pending = rs2_hit && (rs2_reg != '0);

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Randomized scoreboard bench for rv32i_wb_arbiter against a queue-based reference model.
module tb_rv32i_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rg;
        logic [31:0] data;
    } m_ent_t;

    typedef struct {
        int          edge_no;
        logic [4:0]  rg;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][4:0]  req_reg;
    logic [1:0][31:0] req_data;
    logic             wb_enable;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic [4:0]       rs1_reg;
    logic [4:0]       rs2_reg;
    logic             rs1_pending;
    logic             rs2_pending;

    rv32i_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .wb_enable   (wb_enable),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .rs1_reg     (rs1_reg),
        .rs2_reg     (rs2_reg),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    m_ent_t      mq0[$];
    m_ent_t      mq1[$];
    exp_t        sb[$];
    logic        m_lg = 1'b1;
    logic        m_wb_en = 1'b0;
    logic [4:0]  m_hold_reg = '0;
    logic [31:0] m_hold_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic m_pending(input logic [4:0] r);
        if (r == 0) return 1'b0;
        foreach (mq0[i]) if (mq0[i].rg == r) return 1'b1;
        foreach (mq1[i]) if (mq1[i].rg == r) return 1'b1;
        return m_wb_en && (m_hold_reg == r);
    endfunction

    function automatic logic [1:0] m_ready();
        if (!reset) return 2'b00;
        return {logic'(mq1.size() < DEPTH), logic'(mq0.size() < DEPTH)};
    endfunction

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        sb.delete();
        m_lg        = 1'b1;
        m_wb_en     = 1'b0;
        m_hold_reg  = '0;
        m_hold_data = '0;
    endtask

    // One clock edge of the reference: arbitrate on pre-edge occupancy, then enqueue.
    task automatic step(output logic [1:0] acc);
        int     n0;
        int     n1;
        logic   g;
        m_ent_t e;
        @(posedge clk);
        edge_cnt++;
        acc = 2'b00;
        if (!reset) begin
            model_clear();
        end else begin
            n0 = mq0.size();
            n1 = mq1.size();
            acc[0] = req_valid[0] && (n0 < DEPTH);
            acc[1] = req_valid[1] && (n1 < DEPTH);
            if (n0 > 0 || n1 > 0) begin
                if (n0 > 0 && n1 > 0) g = !m_lg;
                else                  g = (n1 > 0);
                if (g) e = mq1.pop_front();
                else   e = mq0.pop_front();
                m_lg = g;
                if (e.rg != 0) begin
                    m_wb_en     = 1'b1;
                    m_hold_reg  = e.rg;
                    m_hold_data = e.data;
                    sb.push_back('{edge_cnt, e.rg, e.data});
                end else begin
                    m_wb_en     = 1'b0;
                    m_hold_reg  = '0;
                    m_hold_data = '0;
                end
            end else begin
                m_wb_en = 1'b0;
            end
            if (acc[0]) mq0.push_back('{req_reg[0], req_data[0]});
            if (acc[1]) mq1.push_back('{req_reg[1], req_data[1]});
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] s1, input logic [4:0] s2);
        req_valid   = v;
        req_reg[0]  = r0;
        req_data[0] = d0;
        req_reg[1]  = r1;
        req_data[1] = d1;
        rs1_reg     = s1;
        rs2_reg     = s2;
    endtask

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic idle(input int n, input logic [4:0] s1, input logic [4:0] s2);
        logic [1:0] acc;
        for (int i = 0; i < n; i++) begin
            drive(2'b00, '0, '0, '0, '0, s1, s2);
            step(acc);
        end
    endtask

    task automatic random_phase(input int n);
        logic [1:0] acc;
        for (int i = 0; i < n; i++) begin
            drive(2'($urandom), rreg(), $urandom, rreg(), $urandom, rreg(), rreg());
            step(acc);
        end
    endtask

    // Scoreboard monitor: pops an expected write whenever one is due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
                e = sb.pop_front();
                chk("wb_enable", 32'(wb_enable), 32'd1);
                chk("wb_reg", 32'(wb_reg), 32'(e.rg));
                chk("wb_data", wb_data, e.data);
            end else begin
                chk("wb_enable_idle", 32'(wb_enable), 32'd0);
                chk("wb_reg_held", 32'(wb_reg), 32'(m_hold_reg));
                chk("wb_data_held", wb_data, m_hold_data);
            end
            chk("req_ready", 32'(req_ready), 32'(m_ready()));
            chk("rs1_pending", 32'(rs1_pending), 32'(m_pending(rs1_reg)));
            chk("rs2_pending", 32'(rs2_pending), 32'(m_pending(rs2_reg)));
        end
    end

    initial begin
        logic [1:0] acc;
        m_ent_t     alu [5];
        int         sent;
        int         guard;

        drive(2'b00, '0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wb_enable", 32'(wb_enable), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;

        // Single ALU write to x10.
        drive(2'b01, 5'd10, 32'h25, '0, '0, 5'd10, 5'd0);
        step(acc);
        idle(4, 5'd10, 5'd0);

        // Two simultaneous pairs.
        drive(2'b11, 5'd5, 32'h20, 5'd7, 32'h141, 5'd5, 5'd7);
        step(acc);
        idle(1, 5'd5, 5'd7);
        drive(2'b11, 5'd5, 32'h20, 5'd7, 32'h141, 5'd5, 5'd7);
        step(acc);
        idle(4, 5'd5, 5'd7);

        // Load writes x0: granted but suppressed.
        drive(2'b10, '0, '0, 5'd0, 32'd321, 5'd0, 5'd0);
        step(acc);
        idle(3, 5'd0, 5'd0);

        // ALU streams five entries while the load unit keeps its queue fed.
        for (int i = 0; i < 5; i++) alu[i] = '{5'($urandom_range(1, 31)), $urandom};
        sent  = 0;
        guard = 0;
        while (sent < 5 && guard < 60) begin
            drive(2'b11, alu[sent].rg, alu[sent].data, rreg(), $urandom, alu[sent].rg, rreg());
            step(acc);
            if (acc[0]) sent++;
            guard++;
        end
        chk("alu_stream_accepted", 32'(sent), 32'd5);
        idle(8, rreg(), rreg());

        random_phase(300);

        // Fill both queues, then pull reset between edges.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom,
                  rreg(), rreg());
            step(acc);
        end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("midreset_wb_enable", 32'(wb_enable), 32'd0);
        chk("midreset_req_ready", 32'(req_ready), 32'd0);
        idle(2, rreg(), rreg());
        reset = 1'b1;
        idle(2, rreg(), rreg());
        drive(2'b10, '0, '0, 5'd12, 32'hABCD, 5'd12, 5'd0);
        step(acc);
        idle(3, 5'd12, 5'd0);

        random_phase(200);
        idle(10, rreg(), rreg());
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
